// File: rtl/phj_pkg.sv
// Shared definitions for the partition-buffer read path.
//   rd_state_t     : reader FSM states (IDLE, READ, DONE)
//   RD_FIFO_DEPTH  : entries in the reader's output FIFO
//   RD_FIFO_CNT_W  : width of an occupancy count for that FIFO (0..depth)
package phj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } rd_state_t;

    localparam int RD_FIFO_DEPTH = 2;
    localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/uram_partition_reader_if.sv
// Bundle of the reader's command, RAM-read and output-stream signals.
//   start_*   : run command handshake (base address, entry count)
//   ram_*     : read port of the partition RAM (registered read, 1 cycle)
//   out_*     : valid/ready payload stream with end-of-run marker
//   busy/done : run status
// modport master : the reader itself
// modport slave  : the surrounding system (command source, RAM, sink)
interface uram_partition_reader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
);
    logic                  start_valid;
    logic                  start_ready;
    logic [ADDR_WIDTH-1:0] start_base;
    logic [ADDR_WIDTH:0]   start_count;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start_valid, start_base, start_count, ram_rdata, out_ready,
        output start_ready, ram_raddr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start_valid, start_base, start_count, ram_rdata, out_ready,
        input  start_ready, ram_raddr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO used to soak up the RAM read latency.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i this cycle
//   push_data_i  : data to store
//   pop_i        : consume the head this cycle
//   head_o       : current head entry (0 when empty after reset)
//   valid_o      : FIFO not empty
//   cnt_o        : occupancy 0..2
// Push and pop in the same cycle leave the count unchanged.
module skid_fifo2
    import phj_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [RD_FIFO_CNT_W-1:0] cnt_o
);

    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [RD_FIFO_CNT_W-1:0] cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < RD_FIFO_DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push_i && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= push_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + RD_FIFO_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - RD_FIFO_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
    assign valid_o = (cnt_q != '0);
    assign cnt_o   = cnt_q;

    // A push into a full FIFO without a matching pop would drop data.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && (cnt_q == RD_FIFO_CNT_W'(RD_FIFO_DEPTH))));

endmodule

// File: rtl/uram_partition_reader.sv
// Read-side controller for a URAM partition buffer. A start command
// (base, count) streams `count` consecutive words, wrapping at the end of
// the RAM, onto a valid/ready output with a last marker and a done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command, RAM read port, output stream, busy/done (master side)
// Reads are issued only when the 2-entry output FIFO is guaranteed room for
// the returning word, so output backpressure never loses data.
module uram_partition_reader
    import phj_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    uram_partition_reader_if.master bus
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int UW = RD_FIFO_CNT_W + 1;

    rd_state_t             state_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CW-1:0]         issue_left_q;
    logic [CW-1:0]         beats_left_q;
    logic                  pending_q;
    logic                  start_ready_q;
    logic                  busy_q;
    logic                  done_q;

    logic [RD_FIFO_CNT_W-1:0] fifo_cnt;
    logic [DATA_WIDTH-1:0]    fifo_head;
    logic                     fifo_valid;
    logic                     pop;
    logic                     issue;
    logic [UW-1:0]            credit_used;

    assign pop = fifo_valid & bus.out_ready;

    // Slots already spoken for: words in the FIFO plus the one in flight
    // from the RAM. A pop this cycle frees a slot for the new read.
    assign credit_used = UW'(fifo_cnt) + UW'(pending_q);
    assign issue = (state_q == READ) && (issue_left_q != '0) &&
                   ((credit_used - UW'(pop)) < UW'(RD_FIFO_DEPTH));

    skid_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pending_q),
        .push_data_i (bus.ram_rdata),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .cnt_o       (fifo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            issue_left_q  <= '0;
            beats_left_q  <= '0;
            pending_q     <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            pending_q <= issue;
            done_q    <= 1'b0;
            if (issue) begin
                rd_ptr_q     <= rd_ptr_q + ADDR_WIDTH'(1);
                issue_left_q <= issue_left_q - CW'(1);
            end
            if (pop) begin
                beats_left_q <= beats_left_q - CW'(1);
            end
            case (state_q)
                IDLE: begin
                    // start_ready comes up one edge after reset release.
                    if (!start_ready_q) begin
                        start_ready_q <= 1'b1;
                    end else if (bus.start_valid) begin
                        rd_ptr_q      <= bus.start_base;
                        issue_left_q  <= bus.start_count;
                        beats_left_q  <= bus.start_count;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (bus.start_count == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (pop && (beats_left_q == CW'(1))) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
                default: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ram_raddr   = rd_ptr_q;
    assign bus.start_ready = start_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.out_valid   = fifo_valid;
    assign bus.out_data    = fifo_head;
    assign bus.out_last    = fifo_valid && (beats_left_q == CW'(1));

    a_no_beat_underflow: assert property (@(posedge clk) disable iff (rst)
        pop |-> (beats_left_q != '0));

endmodule
